// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - table-driven I2C register configuration sequencer
module i2c_cfg_seq #(
    parameter int NUM_REGS   = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] CFG_TABLE = {8'h04, 16'd640, 8'h03, 16'd480},
    parameter int DELAY_MAX  = 255,
    parameter int VERIFY     = 0,
    parameter int MAX_RETRY  = 2,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              i2c_done,
    input  logic              i2c_ack_err,
    input  logic [DATA_W-1:0] i2c_rd_data,
    output logic              i2c_exec,
    output logic              i2c_rh_wl,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [DATA_W-1:0] i2c_wr_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [7:0]        cfg_idx
);
    localparam int         E         = ADDR_W + DATA_W;
    localparam logic [15:0] DLY_LAST  = 16'(DELAY_MAX - 1);
    localparam logic [7:0]  IDX_LAST  = 8'(NUM_REGS - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_DELAY, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT,
        S_NEXT, S_FAIL, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       cnt;
    logic [7:0]        idx, idx_n;
    logic [3:0]        retry;
    logic              rd_phase;
    logic              first;
    logic              done_r, err_r, rh_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [E-1:0]      entry;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;

    // Table is addressed with the next index so a load on entry to WR/RD sees the new entry.
    assign entry    = CFG_TABLE[idx_n*E +: E];
    assign tbl_addr = entry[E-1 -: ADDR_W];
    assign tbl_data = entry[DATA_W-1:0];

    // NEXT/FAIL count as the first delay cycle, so with DELAY_MAX==1 they jump straight to WR.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                idx_n = '0;
                if (cfg_start || (first && AUTO_START != 0)) state_n = S_DELAY;
            end
            S_DELAY:   if (cnt == DLY_LAST) state_n = rd_phase ? S_RD : S_WR;
            S_WR:      state_n = S_WR_WAIT;
            S_WR_WAIT: if (i2c_done) begin
                if (i2c_ack_err)      state_n = S_FAIL;
                else if (VERIFY != 0) state_n = S_DELAY;
                else                  state_n = S_NEXT;
            end
            S_RD:      state_n = S_RD_WAIT;
            S_RD_WAIT: if (i2c_done) begin
                state_n = (i2c_ack_err || i2c_rd_data != tbl_data) ? S_FAIL : S_NEXT;
            end
            S_NEXT: begin
                if (idx == IDX_LAST) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 8'd1;
                    state_n = (DELAY_MAX == 1) ? S_WR : S_DELAY;
                end
            end
            S_FAIL: begin
                if (retry < RETRY_MAX) state_n = (DELAY_MAX == 1) ? S_WR : S_DELAY;
                else                   state_n = S_ERROR;
            end
            S_DONE, S_ERROR: if (cfg_start) begin
                idx_n   = '0;
                state_n = S_DELAY;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            retry    <= '0;
            rd_phase <= 1'b0;
            first    <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            rh_r     <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            first <= 1'b0;
            case (state)
                S_DELAY:        cnt <= cnt + 16'd1;
                S_NEXT, S_FAIL: cnt <= 16'd1;
                default:        cnt <= '0;
            endcase
            if (state_n == S_WR || state_n == S_RD) begin
                addr_r <= tbl_addr;
                data_r <= tbl_data;
                rh_r   <= (state_n == S_RD);
            end
            if (state == S_WR_WAIT)  rd_phase <= (state_n == S_DELAY);
            else if (state == S_RD)  rd_phase <= 1'b0;
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    retry  <= '0;
                end
                S_DONE, S_ERROR: if (cfg_start) begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    retry  <= '0;
                end
                S_NEXT: begin
                    if (idx == IDX_LAST) done_r <= 1'b1;
                    else                 retry  <= '0;
                end
                S_FAIL: begin
                    if (retry < RETRY_MAX) retry <= retry + 4'd1;
                    else                   err_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign i2c_exec    = (state == S_WR) || (state == S_RD);
    assign i2c_rh_wl   = rh_r;
    assign i2c_addr    = addr_r;
    assign i2c_wr_data = data_r;
    assign cfg_busy    = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign cfg_done    = done_r;
    assign cfg_err     = err_r;
    assign cfg_idx     = idx;
endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb/tb_i2c_cfg_seq.sv - directed self-checking bench for i2c_cfg_seq
module tb_i2c_cfg_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [4];
    logic        cfg_start, i2c_done, i2c_ack_err;
    logic [15:0] i2c_rd_data;
    logic        exec_v [4];
    logic        rh_v [4];
    logic        busy_v [4];
    logic        cdone_v [4];
    logic        err_v [4];
    logic [7:0]  addr_v [4];
    logic [7:0]  idx_v [4];
    logic [15:0] wdat_v [4];
    int sel;
    int checks;
    int fails;

    // 0: defaults, 1: verify with one retry, 2: two retries, 3: manual start
    i2c_cfg_seq u_def (
        .clk(clk), .rst(rst_v[0]), .cfg_start(cfg_start), .i2c_done(i2c_done),
        .i2c_ack_err(i2c_ack_err), .i2c_rd_data(i2c_rd_data), .i2c_exec(exec_v[0]),
        .i2c_rh_wl(rh_v[0]), .i2c_addr(addr_v[0]), .i2c_wr_data(wdat_v[0]),
        .cfg_busy(busy_v[0]), .cfg_done(cdone_v[0]), .cfg_err(err_v[0]), .cfg_idx(idx_v[0]));
    i2c_cfg_seq #(.DELAY_MAX(4), .VERIFY(1), .MAX_RETRY(1)) u_ver (
        .clk(clk), .rst(rst_v[1]), .cfg_start(cfg_start), .i2c_done(i2c_done),
        .i2c_ack_err(i2c_ack_err), .i2c_rd_data(i2c_rd_data), .i2c_exec(exec_v[1]),
        .i2c_rh_wl(rh_v[1]), .i2c_addr(addr_v[1]), .i2c_wr_data(wdat_v[1]),
        .cfg_busy(busy_v[1]), .cfg_done(cdone_v[1]), .cfg_err(err_v[1]), .cfg_idx(idx_v[1]));
    i2c_cfg_seq #(.DELAY_MAX(4), .MAX_RETRY(2)) u_rty (
        .clk(clk), .rst(rst_v[2]), .cfg_start(cfg_start), .i2c_done(i2c_done),
        .i2c_ack_err(i2c_ack_err), .i2c_rd_data(i2c_rd_data), .i2c_exec(exec_v[2]),
        .i2c_rh_wl(rh_v[2]), .i2c_addr(addr_v[2]), .i2c_wr_data(wdat_v[2]),
        .cfg_busy(busy_v[2]), .cfg_done(cdone_v[2]), .cfg_err(err_v[2]), .cfg_idx(idx_v[2]));
    i2c_cfg_seq #(.DELAY_MAX(4), .AUTO_START(0)) u_man (
        .clk(clk), .rst(rst_v[3]), .cfg_start(cfg_start), .i2c_done(i2c_done),
        .i2c_ack_err(i2c_ack_err), .i2c_rd_data(i2c_rd_data), .i2c_exec(exec_v[3]),
        .i2c_rh_wl(rh_v[3]), .i2c_addr(addr_v[3]), .i2c_wr_data(wdat_v[3]),
        .cfg_busy(busy_v[3]), .cfg_done(cdone_v[3]), .cfg_err(err_v[3]), .cfg_idx(idx_v[3]));

    function automatic logic [36:0] outs(input int s);
        return {exec_v[s], rh_v[s], addr_v[s], wdat_v[s], busy_v[s], cdone_v[s], err_v[s], idx_v[s]};
    endfunction

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            i2c_done = 1'b0; i2c_ack_err = 1'b0; cfg_start = 1'b0;
        end
    endtask

    // n = cycles from the calling negedge to the cycle carrying the exec pulse
    task automatic wait_exec(input int limit, output bit found, output int n);
        n = 0; found = 1'b0;
        while (n < limit && !found) begin
            @(negedge clk);
            i2c_done = 1'b0; i2c_ack_err = 1'b0; cfg_start = 1'b0;
            n++;
            if (exec_v[sel] === 1'b1) found = 1'b1;
        end
    endtask

    task automatic serve(input bit nack, input logic [15:0] rdata);
        repeat (20) @(negedge clk);
        i2c_done = 1'b1; i2c_ack_err = nack; i2c_rd_data = rdata;
    endtask

    task automatic do_reset(input int s);
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
        i2c_done = 1'b0; i2c_ack_err = 1'b0; cfg_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_v[s] = 1'b0;
        sel = s;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if (outs(0) !== 37'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", outs(0));
        end
    endtask

    task automatic test_defaults();
        bit f; int n;
        wait_exec(1000, f, n);
        checks++;
        if (!(f && n == 256 && rh_v[0] === 1'b0 && addr_v[0] === 8'h03 && wdat_v[0] === 16'd480 && idx_v[0] === 8'd0)) begin
            fails++; $display("FAIL first_exec: got found=%0b cycles=%0d rh=%b addr=%h data=%0d idx=%0d expected 1 256 0 03 480 0", f, n, rh_v[0], addr_v[0], wdat_v[0], idx_v[0]);
        end
        serve(1'b0, 16'd0);
        wait_exec(1000, f, n);
        checks++;
        if (!(f && n == 256 && rh_v[0] === 1'b0 && addr_v[0] === 8'h04 && wdat_v[0] === 16'd640 && idx_v[0] === 8'd1)) begin
            fails++; $display("FAIL second_exec: got found=%0b gap=%0d rh=%b addr=%h data=%0d idx=%0d expected 1 256 0 04 640 1", f, n, rh_v[0], addr_v[0], wdat_v[0], idx_v[0]);
        end
        serve(1'b0, 16'd0);
        idle_cycles(2);
        checks++;
        if ({cdone_v[0], err_v[0], busy_v[0], idx_v[0]} !== {3'b100, 8'd1}) begin
            fails++; $display("FAIL defaults_done: got done=%b err=%b busy=%b idx=%0d expected 1 0 0 1", cdone_v[0], err_v[0], busy_v[0], idx_v[0]);
        end
        wait_exec(600, f, n);
        checks++;
        if (f) begin
            fails++; $display("FAIL defaults_extra_exec: got exec after done expected none");
        end
    endtask

    task automatic test_verify();
        bit f; int n;
        logic [7:0]  ea [4] = '{8'h03, 8'h03, 8'h04, 8'h04};
        logic        er [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] rd [4] = '{16'd0, 16'd480, 16'd0, 16'd640};
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            wait_exec(100, f, n);
            checks++;
            if (!(f && addr_v[1] === ea[i] && rh_v[1] === er[i])) begin
                fails++; $display("FAIL verify_access%0d: got found=%0b addr=%h rh=%b expected 1 %h %b", i, f, addr_v[1], rh_v[1], ea[i], er[i]);
            end
            serve(1'b0, rd[i]);
        end
        idle_cycles(2);
        checks++;
        if ({cdone_v[1], err_v[1]} !== 2'b10) begin
            fails++; $display("FAIL verify_done: got done=%b err=%b expected 1 0", cdone_v[1], err_v[1]);
        end
    endtask

    task automatic test_verify_fail();
        bit f; int n;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            wait_exec(100, f, n);
            checks++;
            if (!(f && addr_v[1] === 8'h03 && rh_v[1] === i[0])) begin
                fails++; $display("FAIL mismatch_access%0d: got found=%0b addr=%h rh=%b expected 1 03 %b", i, f, addr_v[1], rh_v[1], i[0]);
            end
            serve(1'b0, 16'd481);
        end
        idle_cycles(2);
        checks++;
        if ({cdone_v[1], err_v[1], busy_v[1], idx_v[1]} !== {3'b010, 8'd0}) begin
            fails++; $display("FAIL mismatch_error: got done=%b err=%b busy=%b idx=%0d expected 0 1 0 0", cdone_v[1], err_v[1], busy_v[1], idx_v[1]);
        end
        wait_exec(60, f, n);
        checks++;
        if (f) begin
            fails++; $display("FAIL mismatch_extra_exec: got exec after error expected none");
        end
    endtask

    task automatic test_retry();
        bit f; int n;
        logic [7:0] ea [4] = '{8'h03, 8'h03, 8'h03, 8'h04};
        bit         nk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            wait_exec(100, f, n);
            checks++;
            if (!(f && addr_v[2] === ea[i] && rh_v[2] === 1'b0)) begin
                fails++; $display("FAIL retry_access%0d: got found=%0b addr=%h rh=%b expected 1 %h 0", i, f, addr_v[2], rh_v[2], ea[i]);
            end
            serve(nk[i], 16'd0);
        end
        idle_cycles(2);
        checks++;
        if ({cdone_v[2], err_v[2]} !== 2'b10) begin
            fails++; $display("FAIL retry_done: got done=%b err=%b expected 1 0", cdone_v[2], err_v[2]);
        end
    endtask

    task automatic test_reset_midflight();
        bit f; int n;
        do_reset(0);
        wait_exec(400, f, n);
        serve(1'b0, 16'd0);
        wait_exec(400, f, n);
        checks++;
        if (!(f && addr_v[0] === 8'h04)) begin
            fails++; $display("FAIL midflight_entry1: got found=%0b addr=%h expected 1 04", f, addr_v[0]);
        end
        idle_cycles(5);
        rst_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (outs(0) !== 37'd0) begin
            fails++; $display("FAIL midflight_reset_outputs: got %h expected 0", outs(0));
        end
        rst_v[0] = 1'b0;
        i2c_done = 1'b1;
        wait_exec(400, f, n);
        checks++;
        if (!(f && n == 256 && addr_v[0] === 8'h03 && idx_v[0] === 8'd0 && cdone_v[0] === 1'b0)) begin
            fails++; $display("FAIL midflight_restart: got found=%0b cycles=%0d addr=%h idx=%0d done=%b expected 1 256 03 0 0", f, n, addr_v[0], idx_v[0], cdone_v[0]);
        end
    endtask

    task automatic test_manual_start();
        bit f; int n;
        do_reset(3);
        wait_exec(40, f, n);
        checks++;
        if (f || busy_v[3] !== 1'b0) begin
            fails++; $display("FAIL manual_no_autostart: got exec=%0b busy=%b expected 0 0", f, busy_v[3]);
        end
        cfg_start = 1'b1;
        wait_exec(100, f, n);
        checks++;
        if (!(f && addr_v[3] === 8'h03)) begin
            fails++; $display("FAIL manual_first: got found=%0b addr=%h expected 1 03", f, addr_v[3]);
        end
        cfg_start = 1'b1;
        serve(1'b0, 16'd0);
        wait_exec(100, f, n);
        checks++;
        if (!(f && addr_v[3] === 8'h04 && idx_v[3] === 8'd1)) begin
            fails++; $display("FAIL manual_busy_start: got found=%0b addr=%h idx=%0d expected 1 04 1", f, addr_v[3], idx_v[3]);
        end
        serve(1'b0, 16'd0);
        cfg_start = 1'b1;
        idle_cycles(2);
        checks++;
        if ({cdone_v[3], busy_v[3]} !== 2'b10) begin
            fails++; $display("FAIL manual_done: got done=%b busy=%b expected 1 0", cdone_v[3], busy_v[3]);
        end
        wait_exec(40, f, n);
        checks++;
        if (f) begin
            fails++; $display("FAIL manual_done_start: got exec after start-with-done expected none");
        end
        cfg_start = 1'b1;
        idle_cycles(1);
        checks++;
        if ({cdone_v[3], busy_v[3], idx_v[3]} !== {2'b01, 8'd0}) begin
            fails++; $display("FAIL manual_restart_clear: got done=%b busy=%b idx=%0d expected 0 1 0", cdone_v[3], busy_v[3], idx_v[3]);
        end
        for (int i = 0; i < 2; i++) begin
            wait_exec(100, f, n);
            checks++;
            if (!(f && addr_v[3] === (i == 0 ? 8'h03 : 8'h04))) begin
                fails++; $display("FAIL manual_rerun%0d: got found=%0b addr=%h expected 1 %s", i, f, addr_v[3], i == 0 ? "03" : "04");
            end
            serve(1'b0, 16'd0);
        end
        idle_cycles(2);
        checks++;
        if (cdone_v[3] !== 1'b1) begin
            fails++; $display("FAIL manual_rerun_done: got %b expected 1", cdone_v[3]);
        end
    endtask

    initial begin
        checks = 0; fails = 0; sel = 0;
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
        cfg_start = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rd_data = '0;
        test_reset();
        test_defaults();
        test_verify();
        test_verify_fail();
        test_retry();
        test_reset_midflight();
        test_manual_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
